// File: rtl/ifu.sv
// Instruction fetch unit: fetches one 32-bit word per PC over a
// request/grant/response handshake and holds it for the core until it
// is acknowledged. Misaligned PCs, bus errors and response timeouts
// park the unit in a sticky fault state that only reset clears.
module ifu #(
  parameter int          TIMEOUT = 255,
  parameter logic [31:0] NOP     = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic [31:0] pc_in,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        imem_err,
  output logic        fetch_err,
  output logic [31:0] fault_addr
);

  // Wide enough to hold TIMEOUT itself; the counter never exceeds it
  // because reaching TIMEOUT forces the exit from WAIT.
  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_VALID = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]    state_reg,  state_next;
  logic [31:0]   addr_reg,   addr_next;
  logic [CW-1:0] cnt_reg,    cnt_next;
  logic [31:0]   inst_reg,   inst_next;
  logic [31:0]   fault_reg,  fault_next;
  logic [CW-1:0] cnt_inc;
  logic          pc_aligned;

  assign pc_aligned = (pc_in[1:0] == 2'b00);
  assign cnt_inc    = cnt_reg + CW'(1);

  // Next-state and datapath capture decisions for the fetch FSM.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    cnt_next   = cnt_reg;
    inst_next  = inst_reg;
    fault_next = fault_reg;
    case (state_reg)
      S_IDLE: begin
        if (fetch_en) state_next = S_REQ;
      end
      S_REQ: begin
        if (!pc_aligned) begin
          // A misaligned PC never reaches the bus.
          state_next = S_ERR;
          fault_next = pc_in;
        end else if (imem_gnt) begin
          state_next = S_WAIT;
          addr_next  = pc_in;
          cnt_next   = '0;
        end
      end
      S_WAIT: begin
        cnt_next = cnt_inc;
        // A response on the final timeout cycle still wins.
        if (imem_rvalid) begin
          if (imem_err) begin
            state_next = S_ERR;
            fault_next = addr_reg;
          end else begin
            state_next = S_VALID;
            inst_next  = imem_rdata;
          end
        end else if (cnt_inc == TMAX) begin
          state_next = S_ERR;
          fault_next = addr_reg;
        end
      end
      S_VALID: begin
        if (inst_ack) state_next = fetch_en ? S_REQ : S_IDLE;
      end
      S_ERR: begin
        state_next = S_ERR;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and capture registers; reset returns to IDLE immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      cnt_reg   <= '0;
      inst_reg  <= NOP;
      fault_reg <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      cnt_reg   <= cnt_next;
      inst_reg  <= inst_next;
      fault_reg <= fault_next;
    end
  end

  // Outputs decode from registered state only, so no memory-side input
  // ever reaches inst combinationally.
  assign imem_req   = (state_reg == S_REQ) && pc_aligned;
  assign imem_addr  = (state_reg == S_REQ) ? pc_in : 32'h0;
  assign inst_valid = (state_reg == S_VALID);
  assign inst       = inst_valid ? inst_reg : NOP;
  assign fetch_err  = (state_reg == S_ERR);
  assign fault_addr = fault_reg;

endmodule
